arb_mux_n: RTL and testbench

- N-channel valid/ready multiplexer with a built-in arbiter and a registered output stage. Generalises the fixed 4-way combinational select to N channels of WIDTH bits.
- Sequential behaviour: round-robin or fixed-priority arbitration, an output holding register, and backpressure.
- Sits between multiple requesters (e.g. fetch / load-store / debug) and a single shared consumer such as the memory bus port in the rv32i core.

---
 rtl/mux_pkg.sv | 16 +
 rtl/rr_pick.sv | 42 ++++
 rtl/arb_mux_n.sv | 83 ++++++++
 tb/tb_arb_mux_n.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants, helpers and the output-stage state type for the N-way arbitrated mux.
package mux_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  // Width of a channel index; never 0, so a 1-bit index still exists for N = 1..2.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N-1:0]   req2;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;

  assign req2  = {req, req};
  assign found = |req;

  // Rotate by reading the doubled vector starting at ptr, so bit 0 of rot is channel ptr.
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req2[{1'b0, ptr} + (SEL_W+1)'(i)];
    end
  end

  always_comb begin
    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = SEL_W'(i - 1);
    end
  end

  // Explicit modulo-N wrap: N need not be a power of two.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SEL_W+1)'(N)) idx = SEL_W'(sum - (SEL_W+1)'(N));
    else                      idx = SEL_W'(sum);
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel valid/ready mux with round-robin or fixed-priority arbitration and a registered output.
module arb_mux_n
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned N           = 4,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned SEL_W       = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic             found;
  logic [SEL_W-1:0] win;
  logic             load;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  // Gating with rst_n keeps in_ready low and blocks acceptance during the reset cycle.
  assign load = rst_n && found && ((state_q == EMPTY) || out_ready);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    in_ready = '0;
    if (load) begin
      state_d = FULL;
      sel_d   = win;
      for (int unsigned i = 0; i < N; i++) begin
        if (SEL_W'(i) == win) begin
          data_d      = in_data[i*WIDTH +: WIDTH];
          in_ready[i] = 1'b1;
        end
      end
      if (ROUND_ROBIN) ptr_d = (win == SEL_W'(N - 1)) ? '0 : win + SEL_W'(1);
      else             ptr_d = '0;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: three configurations (N=4 RR, N=4 fixed, N=3 RR) against a behavioural model.
module tb_arb_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n0, n1, n2;
  logic [3:0]  v0, v1;
  logic [2:0]  v2;
  logic [31:0] d0, d1;
  logic [23:0] d2;
  logic        r0, r1, r2;
  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic        ov0, ov1, ov2;
  logic [7:0]  od0, od1, od2;
  logic [1:0]  os0, os1, os2;

  arb_mux_n #(.WIDTH(8), .N(4), .ROUND_ROBIN(1'b1)) u0 (
    .clk(clk), .rst_n(n0), .in_valid(v0), .in_data(d0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(r0));
  arb_mux_n #(.WIDTH(8), .N(4), .ROUND_ROBIN(1'b0)) u1 (
    .clk(clk), .rst_n(n1), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(r1));
  arb_mux_n #(.WIDTH(8), .N(3), .ROUND_ROBIN(1'b1)) u2 (
    .clk(clk), .rst_n(n2), .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(r2));

  int checks = 0;
  int passes = 0;
  bit done   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Model state = what each DUT must hold after the most recent rising edge.
  int nch[3]  = '{4, 4, 3};
  bit rrm[3]  = '{1'b1, 1'b0, 1'b1};
  int m_ptr[3]  = '{0, 0, 0};
  bit m_ov[3]   = '{1'b0, 1'b0, 1'b0};
  int m_data[3] = '{0, 0, 0};
  int m_sel[3]  = '{0, 0, 0};

  logic [3:0] mv[3];
  logic [7:0] md[3][4];
  logic       mrdy[3], mrst[3];
  logic [3:0] dir[3];
  logic       dov[3];
  logic [7:0] dod[3];
  logic [1:0] dos[3], dptr[3];

  always @(negedge clk) begin
    if (!done) begin
      mv[0] = v0; mv[1] = v1; mv[2] = {1'b0, v2};
      for (int i = 0; i < 4; i++) begin
        md[0][i] = d0[i*8 +: 8];
        md[1][i] = d1[i*8 +: 8];
        md[2][i] = (i < 3) ? d2[i*8 +: 8] : 8'h00;
      end
      mrdy[0] = r0; mrdy[1] = r1; mrdy[2] = r2;
      mrst[0] = n0; mrst[1] = n1; mrst[2] = n2;
      dir[0] = ir0; dir[1] = ir1; dir[2] = {1'b0, ir2};
      dov[0] = ov0; dov[1] = ov1; dov[2] = ov2;
      dod[0] = od0; dod[1] = od1; dod[2] = od2;
      dos[0] = os0; dos[1] = os1; dos[2] = os2;
      dptr[0] = u0.ptr_q; dptr[1] = u1.ptr_q; dptr[2] = u2.ptr_q;
      for (int k = 0; k < 3; k++) begin
        int win;
        bit ld;
        win = -1;
        if (mrst[k]) begin
          for (int j = 0; j < nch[k]; j++) begin
            int c;
            c = (m_ptr[k] + j) % nch[k];
            if (win < 0 && mv[k][c]) win = c;
          end
        end
        ld = (win >= 0) && (!m_ov[k] || mrdy[k]);
        chk($sformatf("u%0d.in_ready", k), dir[k], ld ? (32'd1 << win) : 32'd0);
        chk($sformatf("u%0d.out_valid", k), dov[k], m_ov[k]);
        chk($sformatf("u%0d.out_data", k), dod[k], m_data[k]);
        chk($sformatf("u%0d.out_sel", k), dos[k], m_sel[k]);
        chk($sformatf("u%0d.ptr", k), dptr[k], m_ptr[k]);
        if (!mrst[k]) begin
          m_ptr[k] = 0; m_ov[k] = 1'b0; m_data[k] = 0; m_sel[k] = 0;
        end else if (ld) begin
          m_data[k] = md[k][win];
          m_sel[k]  = win;
          m_ov[k]   = 1'b1;
          m_ptr[k]  = rrm[k] ? (win + 1) % nch[k] : 0;
        end else if (m_ov[k] && mrdy[k]) begin
          m_ov[k] = 1'b0;
        end
      end
      chk("u2.ptr_below_3", {31'd0, u2.ptr_q < 2'd3}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sel2[4] = '{1, 2, 0, 1};

  initial begin
    n0 = 1'b0; n1 = 1'b0; n2 = 1'b0;
    v0 = 4'b1111; d0 = 32'hA3A2A1A0; r0 = 1'b1;
    v1 = '0; d1 = '0; r1 = 1'b1;
    v2 = '0; d2 = '0; r2 = 1'b1;

    // Reset held for two edges with every channel requesting.
    tick(); tick();
    chk("rst.out_valid", ov0, 0);
    chk("rst.out_data", od0, 0);
    chk("rst.in_ready", ir0, 0);
    n0 = 1'b1; n1 = 1'b1; n2 = 1'b1;
    #1 chk("rr.first_ready", ir0, 4'b0001);

    // Round-robin fairness: A0 A1 A2 A3 A0, ready rotating.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr.out_data", od0, 8'hA0 + 8'(i % 4));
      chk("rr.out_sel", os0, i % 4);
      chk("rr.in_ready", ir0, 4'b0001 << ((i + 1) % 4));
    end
    v0 = 4'b0000;
    tick();

    // Backpressure: hold 0x55 from ch2 while ch1/ch3 wait.
    v0 = 4'b0100; d0 = 32'h00550000;
    tick();
    r0 = 1'b0; v0 = 4'b1010; d0 = 32'h33551100;
    #1 chk("bp.in_ready", ir0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.out_data", od0, 8'h55);
      chk("bp.out_valid", ov0, 1);
      chk("bp.in_ready", ir0, 0);
      chk("bp.ptr", u0.ptr_q, 3);
    end
    r0 = 1'b1;
    #1 chk("bp.release_ready", ir0, 4'b1000);
    tick();
    chk("bp.out_data_ch3", od0, 8'h33);
    chk("bp.out_sel_ch3", os0, 3);
    v0 = 4'b0000;
    tick(); tick();

    // Mid-operation reset discards the held word.
    v0 = 4'b0001; d0 = 32'h00000077; r0 = 1'b0;
    tick();
    chk("mrst.held", od0, 8'h77);
    n0 = 1'b0;
    #1 chk("mrst.in_ready", ir0, 0);
    tick();
    chk("mrst.out_valid", ov0, 0);
    chk("mrst.ptr", u0.ptr_q, 0);
    n0 = 1'b1; v0 = 4'b0000; r0 = 1'b1;
    tick();

    // Fixed priority: ch0 beats ch2 while both request.
    v1 = 4'b0101; d1 = 32'h00C200C0;
    #1 chk("fp.first_ready", ir1, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp.out_data", od1, 8'hC0);
      chk("fp.in_ready", ir1, 4'b0001);
      chk("fp.ptr", u1.ptr_q, 0);
    end
    v1 = 4'b0100;
    #1 chk("fp.ch2_ready", ir1, 4'b0100);
    tick();
    chk("fp.out_data_ch2", od1, 8'hC2);
    chk("fp.out_sel_ch2", os1, 2);
    v1 = 4'b0000; r1 = 1'b0;
    tick();
    r1 = 1'b1;
    tick(); tick();

    // N=3 wrap: ptr=2, only ch0 valid -> grant ch0, ptr becomes 1.
    v2 = 3'b010; d2 = 24'h00B100;
    tick();
    chk("n3.ptr_after_ch1", u2.ptr_q, 2);
    v2 = 3'b001; d2 = 24'h00B1B0;
    #1 chk("n3.wrap_ready", ir2, 3'b001);
    tick();
    chk("n3.out_data", od2, 8'hB0);
    chk("n3.ptr_after_ch0", u2.ptr_q, 1);
    v2 = 3'b111; d2 = 24'hB2B1B0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3.rr_sel", os2, exp_sel2[i]);
    end
    v2 = 3'b000;
    tick(); tick();

    @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
